// File: rtl/octant_pkg.sv
// Shared types and helpers for the octant point sequencer: state encoding,
// point packing layout {x, y, z, 16'h0} and the packing function.
package octant_pkg;

    localparam int COORD_W = 16;
    localparam int POINT_W = 64;

    localparam int X_MSB = 63;
    localparam int Y_MSB = 47;
    localparam int Z_MSB = 31;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SCAN  = 3'd1,
        MID   = 3'd2,
        ISSUE = 3'd3,
        WAIT  = 3'd4,
        DONE  = 3'd5
    } state_e;

    function automatic logic [POINT_W-1:0] pack_point(
        input logic [COORD_W-1:0] x,
        input logic [COORD_W-1:0] y,
        input logic [COORD_W-1:0] z
    );
        logic [POINT_W-1:0] p;
        p = '0;
        p[X_MSB -: COORD_W] = x;
        p[Y_MSB -: COORD_W] = y;
        p[Z_MSB -: COORD_W] = z;
        return p;
    endfunction

endpackage

// File: rtl/octant_bbox_accum.sv
// One axis of the bounding-box scan: signed running min/max with clear,
// direct load, per-point update, and a floor((min+max)/2) mid output.
module octant_bbox_accum #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clear,
    input  logic         i_load,
    input  logic [W-1:0] i_load_min,
    input  logic [W-1:0] i_load_max,
    input  logic         i_update,
    input  logic [W-1:0] i_val,
    output logic [W-1:0] o_min,
    output logic [W-1:0] o_max,
    output logic [W-1:0] o_mid
);

    localparam logic [W-1:0] POS_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] NEG_MAX = {1'b1, {(W-1){1'b0}}};

    logic [W-1:0] min_d, min_q;
    logic [W-1:0] max_d, max_q;
    logic [W:0]   sum;

    always_comb begin
        min_d = min_q;
        max_d = max_q;
        if (i_clear) begin
            min_d = POS_MAX;
            max_d = NEG_MAX;
        end else if (i_load) begin
            min_d = i_load_min;
            max_d = i_load_max;
        end else if (i_update) begin
            if ($signed(i_val) < $signed(min_q)) min_d = i_val;
            if ($signed(i_val) > $signed(max_q)) max_d = i_val;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            min_q <= '0;
            max_q <= '0;
        end else begin
            min_q <= min_d;
            max_q <= max_d;
        end
    end

    // Sign-extended sum keeps the carry; dropping bit 0 is an arithmetic floor shift.
    assign sum   = {min_q[W-1], min_q} + {max_q[W-1], max_q};
    assign o_mid = sum[W:1];
    assign o_min = min_q;
    assign o_max = max_q;

endmodule

// File: rtl/octant_point_sequencer.sv
// Snapshots a point cloud, scans it for the bounding box and mid point, then
// feeds points one by one to the octant core. FIXED_BBOX_EN: take bbox from ports.
module octant_point_sequencer
    import octant_pkg::*;
#(
    parameter int MAX_POINTS = 7,
    parameter int COORD_W    = 16,
    parameter int MAX_DEPTH  = 14
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_en,
    input  logic [15:0]                   i_point_cloud_size,
    input  logic [MAX_POINTS*COORD_W-1:0] i_points_x,
    input  logic [MAX_POINTS*COORD_W-1:0] i_points_y,
    input  logic [MAX_POINTS*COORD_W-1:0] i_points_z,
    input  logic [63:0]                   i_near_bottom_left,
    input  logic [63:0]                   i_far_top_right,
    output logic [63:0]                   o_point,
    output logic                          o_point_valid,
    input  logic                          i_point_ready,
    input  logic                          i_point_done,
    output logic [63:0]                   o_near_bottom_left,
    output logic [63:0]                   o_far_top_right,
    output logic [63:0]                   o_mid_point,
    output logic                          o_bbox_valid,
    output logic [15:0]                   o_point_idx,
    output logic                          o_busy,
    output logic                          o_finish
);

    localparam int IDX_W = (MAX_POINTS > 1) ? $clog2(MAX_POINTS) : 1;
    localparam int CNT_W = $clog2(MAX_POINTS + 1);

    typedef logic [2:0][MAX_POINTS-1:0][COORD_W-1:0] cloud_t;

    state_e             state_d, state_q;
    cloud_t             pts_in, pts_d, pts_q;
    logic [CNT_W-1:0]   nc_in, nc_d, nc_q;
    logic [CNT_W-1:0]   idx_d, idx_q;
    logic [CNT_W-1:0]   scan_d, scan_q;
    logic               armed_d, armed_q;
    logic               busy_d, busy_q;
    logic               finish_d, finish_q;
    logic               pvalid_d, pvalid_q;
    logic               bbox_valid_d, bbox_valid_q;
    logic [POINT_W-1:0] point_d, point_q;
    logic [POINT_W-1:0] nbl_d, nbl_q;
    logic [POINT_W-1:0] ftr_d, ftr_q;
    logic [POINT_W-1:0] mid_d, mid_q;

    logic                    acc_clear, acc_load, acc_update;
    logic [2:0][COORD_W-1:0] acc_val, acc_min, acc_max, acc_mid;
    logic [2:0][COORD_W-1:0] ld_min, ld_max;
    logic [IDX_W-1:0]        scan_sel, idx_sel;
    logic                    unused_ok;

    assign scan_sel = scan_q[IDX_W-1:0];
    assign idx_sel  = idx_q[IDX_W-1:0];

    always_comb begin
        pts_in = '0;
        for (int k = 0; k < MAX_POINTS; k++) begin
            pts_in[0][k] = i_points_x[k*COORD_W +: COORD_W];
            pts_in[1][k] = i_points_y[k*COORD_W +: COORD_W];
            pts_in[2][k] = i_points_z[k*COORD_W +: COORD_W];
        end
    end

    always_comb begin
        if (i_point_cloud_size > 16'(MAX_POINTS)) nc_in = CNT_W'(MAX_POINTS);
        else                                      nc_in = i_point_cloud_size[CNT_W-1:0];
    end

    always_comb begin
        ld_min  = '0;
        ld_max  = '0;
        acc_val = '0;
        for (int a = 0; a < 3; a++) begin
            acc_val[a] = pts_q[a][scan_sel];
`ifdef FIXED_BBOX_EN
            ld_min[a] = i_near_bottom_left[X_MSB - a*COORD_W -: COORD_W];
            ld_max[a] = i_far_top_right[X_MSB - a*COORD_W -: COORD_W];
`endif
        end
    end

    for (genvar a = 0; a < 3; a++) begin : g_axis
        octant_bbox_accum #(.W(COORD_W)) u_acc (
            .i_clk      (i_clk),
            .i_rst_n    (i_rst_n),
            .i_clear    (acc_clear),
            .i_load     (acc_load),
            .i_load_min (ld_min[a]),
            .i_load_max (ld_max[a]),
            .i_update   (acc_update),
            .i_val      (acc_val[a]),
            .o_min      (acc_min[a]),
            .o_max      (acc_max[a]),
            .o_mid      (acc_mid[a])
        );
    end

    always_comb begin
        state_d      = state_q;
        pts_d        = pts_q;
        nc_d         = nc_q;
        idx_d        = idx_q;
        scan_d       = scan_q;
        armed_d      = armed_q;
        busy_d       = busy_q;
        finish_d     = 1'b0;
        pvalid_d     = pvalid_q;
        bbox_valid_d = bbox_valid_q;
        point_d      = point_q;
        nbl_d        = nbl_q;
        ftr_d        = ftr_q;
        mid_d        = mid_q;
        acc_clear    = 1'b0;
        acc_load     = 1'b0;
        acc_update   = 1'b0;

        if (!i_en) armed_d = 1'b1;

        // Dropping the run request anywhere mid-run abandons it without a finish.
        if (state_q != IDLE && !i_en) begin
            state_d      = IDLE;
            pvalid_d     = 1'b0;
            busy_d       = 1'b0;
            bbox_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_en && armed_q) begin
                        pts_d        = pts_in;
                        nc_d         = nc_in;
                        idx_d        = '0;
                        scan_d       = '0;
                        busy_d       = 1'b1;
                        bbox_valid_d = 1'b0;
                        nbl_d        = '0;
                        ftr_d        = '0;
                        mid_d        = '0;
`ifdef FIXED_BBOX_EN
                        acc_load = 1'b1;
                        state_d  = (nc_in == '0) ? DONE : MID;
`else
                        acc_clear = 1'b1;
                        state_d   = (nc_in == '0) ? DONE : SCAN;
`endif
                    end
                end
                SCAN: begin
                    acc_update = 1'b1;
                    scan_d     = scan_q + CNT_W'(1);
                    if (scan_q + CNT_W'(1) == nc_q) state_d = MID;
                end
                MID: begin
                    nbl_d        = pack_point(acc_min[0], acc_min[1], acc_min[2]);
                    ftr_d        = pack_point(acc_max[0], acc_max[1], acc_max[2]);
                    mid_d        = pack_point(acc_mid[0], acc_mid[1], acc_mid[2]);
                    bbox_valid_d = 1'b1;
                    state_d      = ISSUE;
                end
                ISSUE: begin
                    if (!pvalid_q) begin
                        pvalid_d = 1'b1;
                        point_d  = pack_point(pts_q[0][idx_sel], pts_q[1][idx_sel],
                                              pts_q[2][idx_sel]);
                    end else if (i_point_ready) begin
                        pvalid_d = 1'b0;
                        state_d  = WAIT;
                    end
                end
                WAIT: begin
                    if (i_point_done) begin
                        if (idx_q + CNT_W'(1) == nc_q) begin
                            state_d = DONE;
                        end else begin
                            idx_d   = idx_q + CNT_W'(1);
                            state_d = ISSUE;
                        end
                    end
                end
                DONE: begin
                    finish_d = 1'b1;
                    busy_d   = 1'b0;
                    armed_d  = 1'b0;
                    state_d  = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            pts_q        <= '0;
            nc_q         <= '0;
            idx_q        <= '0;
            scan_q       <= '0;
            armed_q      <= 1'b1;
            busy_q       <= 1'b0;
            finish_q     <= 1'b0;
            pvalid_q     <= 1'b0;
            bbox_valid_q <= 1'b0;
            point_q      <= '0;
            nbl_q        <= '0;
            ftr_q        <= '0;
            mid_q        <= '0;
        end else begin
            state_q      <= state_d;
            pts_q        <= pts_d;
            nc_q         <= nc_d;
            idx_q        <= idx_d;
            scan_q       <= scan_d;
            armed_q      <= armed_d;
            busy_q       <= busy_d;
            finish_q     <= finish_d;
            pvalid_q     <= pvalid_d;
            bbox_valid_q <= bbox_valid_d;
            point_q      <= point_d;
            nbl_q        <= nbl_d;
            ftr_q        <= ftr_d;
            mid_q        <= mid_d;
        end
    end

    assign o_point            = point_q;
    assign o_point_valid      = pvalid_q;
    assign o_near_bottom_left = nbl_q;
    assign o_far_top_right    = ftr_q;
    assign o_mid_point        = mid_q;
    assign o_bbox_valid       = bbox_valid_q;
    assign o_point_idx        = 16'(idx_q);
    assign o_busy             = busy_q;
    assign o_finish           = finish_q;

    // Fixed-bbox ports only matter in one build; depth is passed through to the core.
    assign unused_ok = ^{i_near_bottom_left, i_far_top_right, 32'(MAX_DEPTH)};

endmodule

// File: tb/tb_octant_point_sequencer.sv
// Bench for octant_point_sequencer: table of reference clouds, hand-written
// corner sequences, and randomized clouds against a plain min/max/floor model.
module tb_octant_point_sequencer;

    localparam int MAXP = 7;
    localparam int CW   = 16;

    logic              i_clk = 1'b0;
    logic              i_rst_n;
    logic              i_en;
    logic [15:0]       i_point_cloud_size;
    logic [MAXP*CW-1:0] i_points_x, i_points_y, i_points_z;
    logic [63:0]       i_near_bottom_left, i_far_top_right;
    logic [63:0]       o_point;
    logic              o_point_valid;
    logic              i_point_ready;
    logic              i_point_done;
    logic [63:0]       o_near_bottom_left, o_far_top_right, o_mid_point;
    logic              o_bbox_valid;
    logic [15:0]       o_point_idx;
    logic              o_busy;
    logic              o_finish;

    always #5 i_clk = ~i_clk;

    octant_point_sequencer #(.MAX_POINTS(MAXP), .COORD_W(CW), .MAX_DEPTH(14)) dut (
        .i_clk              (i_clk),
        .i_rst_n            (i_rst_n),
        .i_en               (i_en),
        .i_point_cloud_size (i_point_cloud_size),
        .i_points_x         (i_points_x),
        .i_points_y         (i_points_y),
        .i_points_z         (i_points_z),
        .i_near_bottom_left (i_near_bottom_left),
        .i_far_top_right    (i_far_top_right),
        .o_point            (o_point),
        .o_point_valid      (o_point_valid),
        .i_point_ready      (i_point_ready),
        .i_point_done       (i_point_done),
        .o_near_bottom_left (o_near_bottom_left),
        .o_far_top_right    (o_far_top_right),
        .o_mid_point        (o_mid_point),
        .o_bbox_valid       (o_bbox_valid),
        .o_point_idx        (o_point_idx),
        .o_busy             (o_busy),
        .o_finish           (o_finish)
    );

    int n_vec = 0;
    int n_err = 0;

    int cx[MAXP], cy[MAXP], cz[MAXP];

    int          r_lat, r_fin_cnt, r_fin_t, r_hold_left, r_stab_err;
    bit          r_timeout;
    logic [63:0] r_pts[$];
    int          r_idx[$];
    logic [63:0] r_nbl, r_ftr, r_mid;
    logic        r_bbv;

    typedef struct {
        int          size;
        int          nc;
        int          lat;
        int          fin_t;
        logic        bbv;
        logic [63:0] nbl;
        logic [63:0] ftr;
        logic [63:0] mid;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_i(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] pk(input int x, input int y, input int z);
        logic [63:0] p;
        p = {x[15:0], y[15:0], z[15:0], 16'h0};
        return p;
    endfunction

    // floor((a+b)/2) on plain integers
    function automatic int fmid(input int a, input int b);
        int s;
        s = a + b;
        return (s >= 0) ? s / 2 : -((1 - s) / 2);
    endfunction

    task automatic load_cloud();
        for (int k = 0; k < MAXP; k++) begin
            i_points_x[k*CW +: CW] = cx[k][15:0];
            i_points_y[k*CW +: CW] = cy[k][15:0];
            i_points_z[k*CW +: CW] = cz[k][15:0];
        end
    endtask

    task automatic idle_low(input int n);
        i_en = 1'b0; i_point_ready = 1'b0; i_point_done = 1'b0;
        repeat (n) @(negedge i_clk);
    endtask

    task automatic run_cloud(input int size, input bit rnd_rdy, input bit rnd_done,
                             input int hold_idx, input int hold_cyc, input int done_dly,
                             input int abort_idx, input bit scramble);
        int t, pending, abort_st;
        logic [63:0] held;
        bit held_v, post;
        r_lat = -1; r_fin_cnt = 0; r_fin_t = -1; r_hold_left = hold_cyc; r_stab_err = 0;
        r_timeout = 1; r_pts.delete(); r_idx.delete();
        r_nbl = '0; r_ftr = '0; r_mid = '0; r_bbv = 1'b0;
        t = -1; pending = 0; abort_st = 0; held = '0; held_v = 0; post = 0;
        i_point_cloud_size = 16'(size);
        i_point_ready = 1'b0; i_point_done = 1'b0; i_en = 1'b1;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge i_clk);
            t++;
            if (scramble && t == 1) begin
                for (int k = 0; k < MAXP; k++) begin
                    i_points_x[k*CW +: CW] = 16'($urandom);
                    i_points_y[k*CW +: CW] = 16'($urandom);
                    i_points_z[k*CW +: CW] = 16'($urandom);
                end
            end
            if (abort_st == 2) begin
                chk("abort_busy", 64'(o_busy), 64'(0));
                chk("abort_valid", 64'(o_point_valid), 64'(0));
                chk("abort_bbox_valid", 64'(o_bbox_valid), 64'(0));
                chk("abort_finish", 64'(o_finish), 64'(0));
                chk_i("abort_fin_cnt", r_fin_cnt, 0);
                r_timeout = 0;
                return;
            end
            if (abort_st == 1) begin
                i_en = 1'b0; i_point_ready = 1'b0; i_point_done = 1'b0;
                abort_st = 2;
                continue;
            end
            if (post) begin
                chk("finish_width", 64'(o_finish), 64'(0));
                r_timeout = 0;
                break;
            end
            if (pending > 0) begin
                pending--;
                i_point_done = (pending == 0);
            end else begin
                i_point_done = rnd_done ? ($urandom_range(0, 3) == 0) : 1'b0;
            end
            if (o_point_valid && r_lat < 0) r_lat = t;
            if (o_finish) begin
                r_fin_cnt++; r_fin_t = t; post = 1;
                r_nbl = o_near_bottom_left; r_ftr = o_far_top_right;
                r_mid = o_mid_point; r_bbv = o_bbox_valid;
            end
            if (o_point_valid && int'(o_point_idx) == hold_idx && r_hold_left > 0) begin
                if (held_v && o_point !== held) r_stab_err++;
                held = o_point; held_v = 1; i_point_ready = 1'b0; r_hold_left--;
            end else begin
                i_point_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (o_point_valid && i_point_ready) begin
                if (held_v && int'(o_point_idx) == hold_idx && o_point !== held) r_stab_err++;
                r_pts.push_back(o_point);
                r_idx.push_back(int'(o_point_idx));
                pending = done_dly;
                if (int'(o_point_idx) == abort_idx) abort_st = 1;
            end
        end
        if (r_timeout) begin
            n_vec++; n_err++;
            $display("FAIL run_timeout: size %0d got no finish, required one within budget", size);
        end
    endtask

    task automatic check_seq(input string tag, input int nc);
        int n;
        chk_i({tag, "_issued"}, r_pts.size(), nc);
        n = (r_pts.size() < nc) ? r_pts.size() : nc;
        for (int k = 0; k < n; k++) begin
            chk({tag, "_point"}, r_pts[k], pk(cx[k], cy[k], cz[k]));
            chk_i({tag, "_idx"}, r_idx[k], k);
        end
    endtask

    initial begin
        int nc, mnx, mny, mnz, mxx, mxy, mxz, size;
        logic signed [15:0] v;

        cx = '{257, 272, -993, -286, -1325, -302, -1640};
        cy = '{-42, -45, -154, -45, -218, -49, -271};
        cz = '{-155, -155, -154, -155, -157, -154, -155};

        tbl[0] = '{7, 7, 9, 37, 1'b1, pk(-1640, -271, -157), pk(272, -42, -154), pk(-684, -157, -156)};
        tbl[1] = '{20, 7, 9, 37, 1'b1, pk(-1640, -271, -157), pk(272, -42, -154), pk(-684, -157, -156)};
        tbl[2] = '{0, 0, -1, 1, 1'b0, 64'h0, 64'h0, 64'h0};
        tbl[3] = '{3, 3, 5, 17, 1'b1, pk(-993, -154, -155), pk(272, -42, -154), pk(-361, -98, -155)};
        tbl[4] = '{1, 1, 3, 7, 1'b1, pk(257, -42, -155), pk(257, -42, -155), pk(257, -42, -155)};

        i_rst_n = 1'b0; i_en = 1'b0; i_point_cloud_size = '0;
        i_points_x = '0; i_points_y = '0; i_points_z = '0;
        i_near_bottom_left = '0; i_far_top_right = '0;
        i_point_ready = 1'b0; i_point_done = 1'b0;
        repeat (3) @(negedge i_clk);

        chk("rst_point", o_point, 64'h0);
        chk("rst_bbox", {o_near_bottom_left ^ o_far_top_right ^ o_mid_point}, 64'h0);
        chk("rst_ctrl", 64'({o_point_valid, o_bbox_valid, o_busy, o_finish, o_point_idx}), 64'h0);
        i_rst_n = 1'b1;
        idle_low(2);

        // reference clouds from the table
        load_cloud();
        for (int i = 0; i < 5; i++) begin
            run_cloud(tbl[i].size, 0, 0, -1, 0, 2, -1, 0);
            chk_i("tbl_first_valid", r_lat, tbl[i].lat);
            chk_i("tbl_fin_cnt", r_fin_cnt, 1);
            chk_i("tbl_fin_t", r_fin_t, tbl[i].fin_t);
            chk("tbl_bbox_valid", 64'(r_bbv), 64'(tbl[i].bbv));
            chk("tbl_nbl", r_nbl, tbl[i].nbl);
            chk("tbl_ftr", r_ftr, tbl[i].ftr);
            chk("tbl_mid", r_mid, tbl[i].mid);
            check_seq("tbl", tbl[i].nc);
            idle_low(2);
            chk("tbl_bbox_persist", 64'({o_bbox_valid, o_busy}), 64'({tbl[i].bbv, 1'b0}));
        end

        // backpressure on point 3
        run_cloud(7, 0, 0, 3, 5, 2, -1, 0);
        chk_i("bp_hold_cycles_left", r_hold_left, 0);
        chk_i("bp_stability_errors", r_stab_err, 0);
        check_seq("bp", 7);
        idle_low(2);

        // abort in WAIT of point 2, then restart from idx 0
        run_cloud(7, 0, 0, -1, 0, 2, 2, 0);
        check_seq("abort", 3);
        idle_low(1);
        run_cloud(7, 0, 0, -1, 0, 2, -1, 0);
        check_seq("restart", 7);
        chk_i("restart_fin_cnt", r_fin_cnt, 1);

        // held-high i_en after finish must not retrigger
        for (int c = 0; c < 8; c++) begin
            @(negedge i_clk);
            chk("held_en_no_restart", 64'({o_busy, o_point_valid}), 64'h0);
        end
        i_en = 1'b0;
        @(negedge i_clk);
        i_en = 1'b1;
        repeat (2) @(negedge i_clk);
        chk("rearm_restart_busy", 64'(o_busy), 64'(1));
        idle_low(2);

        // synchronous reset while a point is presented
        i_point_cloud_size = 16'(7);
        i_en = 1'b1; i_point_ready = 1'b0;
        for (int c = 0; c < 40 && !o_point_valid; c++) @(negedge i_clk);
        chk("rst_mid_issue_reached", 64'(o_point_valid), 64'(1));
        i_rst_n = 1'b0;
        @(negedge i_clk);
        chk("rst_mid_point", o_point, 64'h0);
        chk("rst_mid_bbox", {o_near_bottom_left | o_far_top_right | o_mid_point}, 64'h0);
        chk("rst_mid_ctrl", 64'({o_point_valid, o_bbox_valid, o_busy, o_finish, o_point_idx}), 64'h0);
        i_rst_n = 1'b1;
        idle_low(2);

        // randomized clouds against the model; inputs scrambled after the start edge
        for (int it = 0; it < 25; it++) begin
            for (int k = 0; k < MAXP; k++) begin
                if (it % 2 == 0) begin
                    v = 16'($urandom); cx[k] = int'(v);
                    v = 16'($urandom); cy[k] = int'(v);
                    v = 16'($urandom); cz[k] = int'(v);
                end else begin
                    cx[k] = $urandom_range(0, 8) - 4;
                    cy[k] = $urandom_range(0, 8) - 4;
                    cz[k] = $urandom_range(0, 8) - 4;
                end
            end
            load_cloud();
            size = $urandom_range(0, 10);
            nc = (size > MAXP) ? MAXP : size;
            run_cloud(size, 1, 1, -1, 0, $urandom_range(1, 3), -1, 1);
            chk_i("rnd_fin_cnt", r_fin_cnt, 1);
            check_seq("rnd", nc);
            if (nc == 0) begin
                chk_i("rnd_no_valid", r_lat, -1);
                chk_i("rnd_fin_t", r_fin_t, 1);
                chk("rnd_empty_bbox", {r_nbl | r_ftr | r_mid}, 64'h0);
                chk("rnd_empty_bbv", 64'(r_bbv), 64'(0));
            end else begin
                mnx = cx[0]; mny = cy[0]; mnz = cz[0];
                mxx = cx[0]; mxy = cy[0]; mxz = cz[0];
                for (int k = 1; k < nc; k++) begin
                    if (cx[k] < mnx) mnx = cx[k];
                    if (cx[k] > mxx) mxx = cx[k];
                    if (cy[k] < mny) mny = cy[k];
                    if (cy[k] > mxy) mxy = cy[k];
                    if (cz[k] < mnz) mnz = cz[k];
                    if (cz[k] > mxz) mxz = cz[k];
                end
                chk_i("rnd_first_valid", r_lat, nc + 2);
                chk("rnd_bbv", 64'(r_bbv), 64'(1));
                chk("rnd_nbl", r_nbl, pk(mnx, mny, mnz));
                chk("rnd_ftr", r_ftr, pk(mxx, mxy, mxz));
                chk("rnd_mid", r_mid, pk(fmid(mnx, mxx), fmid(mny, mxy), fmid(mnz, mxz)));
            end
            idle_low(2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
